// File: rtl/camlink_frame_gen.sv
// Camera Link base-configuration frame timing generator.
// Reads pixels from a standard-latency FIFO and emits FVAL/LVAL/DVAL-framed
// pixel data. Frames are started by a falling edge of either the external
// sync pin or an internal free-running sync. The generator stalls on FIFO
// underflow, flags sync edges that arrive mid-frame and counts completed frames.
module camlink_frame_gen #(
   parameter int DATA_W    = 16,
   parameter int H_ACTIVE  = 320,
   parameter int V_ACTIVE  = 256,
   parameter int V_SETUP   = 10,
   parameter int H_BLANK   = 6,
   parameter int V_HOLD    = 2,
   parameter int SYNC_HALF = 66001
) (
   input  logic              pClk,
   input  logic              nrst,
   input  logic              sync_sel,
   input  logic              sync_ext,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dat,
   output logic              fifo_rd,
   output logic              fval,
   output logic              lval,
   output logic              dval,
   output logic [DATA_W-1:0] pix_dat,
   output logic              frame_done,
   output logic              underflow,
   output logic              sync_miss,
   output logic [15:0]       frame_cnt
);

   localparam int PC_W = $clog2(H_ACTIVE + 1);
   localparam int LC_W = $clog2(V_ACTIVE + 1);
   localparam int SC_W = $clog2(SYNC_HALF + 1);
   localparam int TMAX = (V_SETUP > H_BLANK) ? ((V_SETUP > V_HOLD) ? V_SETUP : V_HOLD)
                                             : ((H_BLANK > V_HOLD) ? H_BLANK : V_HOLD);
   localparam int TC_W = $clog2(TMAX + 1);

   // The FIFO is read one cycle before LVAL rises, so SETUP and HBLANK
   // run one cycle short of their visible length; a length of 1 skips them.
   localparam logic [TC_W-1:0] SETUP_END  = TC_W'((V_SETUP >= 2) ? V_SETUP - 2 : 0);
   localparam logic [TC_W-1:0] HBLANK_END = TC_W'((H_BLANK >= 2) ? H_BLANK - 2 : 0);
   localparam logic [TC_W-1:0] VHOLD_END  = TC_W'(V_HOLD - 1);
   localparam logic [SC_W-1:0] SYNC_END   = SC_W'(SYNC_HALF - 1);
   localparam logic [PC_W-1:0] PC_FULL    = PC_W'(H_ACTIVE);
   localparam logic [LC_W-1:0] LC_LAST    = LC_W'(V_ACTIVE - 1);

   typedef enum logic [2:0] {ARM, SETUP, LINE, HBLANK, VHOLD} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [TC_W-1:0]   tc;
   logic [PC_W-1:0]   pc;
   logic [LC_W-1:0]   lc;
   logic [SC_W-1:0]   sc;
   logic              int_sync;
   logic              sync_lvl;
   logic              s1;
   logic              s2;
   logic              s_hist;
   logic              sync_fall;
   logic              line_end;
   logic              vld_p1;

   assign sync_lvl  = sync_sel ? sync_ext : int_sync;
   assign sync_fall = s_hist & ~s2;

   // Internal free-running sync: toggles every SYNC_HALF cycles in every state.
   always_ff @(posedge pClk) begin
      if (!nrst) begin
         sc       <= '0;
         int_sync <= 1'b0;
      end else if (sc == SYNC_END) begin
         sc       <= '0;
         int_sync <= ~int_sync;
      end else begin
         sc       <= sc + 1'b1;
      end
   end

   // Two-flop synchroniser plus history flop for falling-edge detection.
   always_ff @(posedge pClk) begin
      if (!nrst) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         s_hist <= 1'b0;
      end else begin
         s1     <= sync_lvl;
         s2     <= s1;
         s_hist <= s2;
      end
   end

   // Next-state decode, FIFO read strobe and end-of-line detection.
   always_comb begin
      state_nxt = state;
      fifo_rd   = (state == LINE) && (pc < PC_FULL) && !fifo_empty;
      line_end  = (state == LINE) && (pc == PC_FULL) && !vld_p1;
      case (state)
         ARM:     if (sync_fall) state_nxt = (V_SETUP >= 2) ? SETUP : LINE;
         SETUP:   if (tc == SETUP_END) state_nxt = LINE;
         LINE:    if (line_end)
                     state_nxt = (lc == LC_LAST) ? VHOLD : ((H_BLANK >= 2) ? HBLANK : LINE);
         HBLANK:  if (tc == HBLANK_END) state_nxt = LINE;
         VHOLD:   if (tc == VHOLD_END) state_nxt = ARM;
         default: state_nxt = ARM;
      endcase
   end

   // State register, timing counters, framing strobes and status flags.
   always_ff @(posedge pClk) begin
      if (!nrst) begin
         state      <= ARM;
         tc         <= '0;
         pc         <= '0;
         lc         <= '0;
         vld_p1     <= 1'b0;
         fval       <= 1'b0;
         lval       <= 1'b0;
         dval       <= 1'b0;
         frame_done <= 1'b0;
         underflow  <= 1'b0;
         sync_miss  <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         frame_done <= 1'b0;
         // p0 -> p1: read issued, FIFO data appears on fifo_dat next cycle
         vld_p1     <= fifo_rd;
         // p1 -> p2: data captured into pix_dat alongside dval
         dval       <= vld_p1;

         if (state_nxt != state)
            tc <= '0;
         else if (state == SETUP || state == HBLANK || state == VHOLD)
            tc <= tc + 1'b1;

         if (line_end)
            pc <= '0;
         else if (fifo_rd)
            pc <= pc + 1'b1;

         if (state != ARM && sync_fall)
            sync_miss <= 1'b1;

         case (state)
            ARM: begin
               if (sync_fall) begin
                  fval      <= 1'b1;
                  underflow <= 1'b0;
                  sync_miss <= 1'b0;
                  lc        <= '0;
               end
            end
            LINE: begin
               lval <= !line_end;
               if ((pc < PC_FULL) && fifo_empty)
                  underflow <= 1'b1;
               if (line_end)
                  lc <= lc + 1'b1;
            end
            VHOLD: begin
               if (tc == VHOLD_END) begin
                  fval       <= 1'b0;
                  frame_done <= 1'b1;
                  frame_cnt  <= frame_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // p1 -> p2: pixel data register, loaded when a read's data is on fifo_dat.
   always_ff @(posedge pClk) begin
      if (!nrst)
         pix_dat <= '0;
      else if (vld_p1)
         pix_dat <= fifo_dat;
   end

endmodule
